// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keyboard_pkg
//  Purpose  : Shared constants and types for the PS/2 keyboard controller:
//             register offsets (addr[3:2]), receiver state encoding and a
//             saturating-increment helper.
//  Revision : 1.0  initial release
// ============================================================================
package keyboard_pkg;

    // Register offsets as seen on cpu_addr_in[3:2]
    localparam logic [1:0] KBD_REG_STATUS = 2'd0;
    localparam logic [1:0] KBD_REG_DATA   = 2'd1;
    localparam logic [1:0] KBD_REG_ERRCNT = 2'd2;
    localparam logic [1:0] KBD_REG_RSVD   = 2'd3;

    // PS/2 frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage : keyboard_pkg
`default_nettype wire

// File: rtl/keyboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : keyboard_if
//  Purpose  : CPU-side register bus of the keyboard controller (address,
//             write data, byte write enables, registered read data).
//  Revision : 1.0  initial release
// ============================================================================
interface keyboard_if;
    import keyboard_pkg::*;

    logic [31:0] cpu_addr_in;
    logic [31:0] cpu_data_in;
    logic [3:0]  cpu_write_enable_in;
    logic [31:0] cpu_data_out;

    // CPU / memory controller side
    modport master (
        output cpu_addr_in,
        output cpu_data_in,
        output cpu_write_enable_in,
        input  cpu_data_out
    );

    // Keyboard controller side
    modport slave (
        input  cpu_addr_in,
        input  cpu_data_in,
        input  cpu_write_enable_in,
        output cpu_data_out
    );
endinterface : keyboard_if
`default_nettype wire

// File: rtl/keyboard_ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx
//  Purpose  : PS/2 frame receiver. Synchronises the raw PS/2 lines, glitch-
//             filters the clock, decodes 11-bit frames on filtered falling
//             edges and abandons a frame after TIMEOUT_CYCLES of silence.
//             Emits a 1-cycle byte_valid_o strobe for good frames and a
//             1-cycle err_o strobe for parity/stop errors and timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_rx
    import keyboard_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       err_o
);

    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_filt_q;
    logic [FLT_W-1:0] flt_cnt_q;

    rx_state_t        state_q,  state_d;
    logic [7:0]       shift_q,  shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             par_q,    par_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             valid_q,  valid_d;
    logic             err_q,    err_d;

    logic w_data;
    logic w_flt_diff;
    logic w_flt_accept;
    logic w_fall;

    // Two-flop synchronisers; idle-high lines so reset to 1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0],  ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    assign w_data       = data_sync_q[1];
    assign w_flt_diff   = (clk_sync_q[1] != clk_filt_q);
    assign w_flt_accept = w_flt_diff && (flt_cnt_q == FLT_LAST);
    // A fall is the filtered clock being accepted at 0 while it was 1
    assign w_fall       = w_flt_accept && clk_filt_q;

    // Glitch filter: a new level is taken after FILTER_LEN consecutive samples
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else if (!w_flt_diff) begin
            flt_cnt_q  <= '0;
        end else if (w_flt_accept) begin
            clk_filt_q <= clk_sync_q[1];
            flt_cnt_q  <= '0;
        end else begin
            flt_cnt_q  <= flt_cnt_q + FLT_W'(1);
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            to_cnt_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            to_cnt_q <= to_cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Next-state: frame decode on each fall, silence timeout otherwise
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        to_cnt_d = to_cnt_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (state_q == IDLE || w_fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            state_d  = IDLE;
            to_cnt_d = '0;
            err_d    = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (w_fall) begin
            case (state_q)
                IDLE: begin
                    if (!w_data) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                        par_d    = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = {w_data, shift_q[7:1]};
                    par_d   = par_q ^ w_data;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    // par_q ends up 1 when data+parity hold an odd number of ones
                    par_d   = par_q ^ w_data;
                    state_d = STOP;
                end
                STOP: begin
                    if (par_q && w_data) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;
    assign err_o        = err_q;

endmodule : ps2_rx
`default_nettype wire

// File: rtl/keyboard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : keyboard_controller
//  Purpose  : PS/2 keyboard receiver with a scancode FIFO and a 4-register
//             memory-mapped window (STATUS, DATA, ERRCNT, reserved).
//             Optional feature macro: KEYBOARD_ERROR_COUNT_EN enables the
//             8-bit saturating frame-error counter behind ERRCNT.
//  Revision : 1.0  initial release
// ============================================================================
module keyboard_controller
    import keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    keyboard_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [31:0]   data_out_q;

    logic          w_rx_valid;
    logic [7:0]    w_rx_byte;
    logic          w_rx_err;
    logic          w_wr;
    logic [1:0]    w_reg;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [7:0]    w_errcnt;
    logic [31:0]   w_rdata;
    logic          w_unused;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .ps2_clk_i    (ps2_clk_in),
        .ps2_data_i   (ps2_data_in),
        .byte_valid_o (w_rx_valid),
        .byte_o       (w_rx_byte),
        .err_o        (w_rx_err)
    );

    assign w_wr    = |bus.cpu_write_enable_in;
    assign w_reg   = bus.cpu_addr_in[3:2];
    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == FULL_COUNT);

    // Pop frees a slot first, so a push in the same cycle is taken even when full
    assign w_pop     = w_wr && (w_reg == KBD_REG_DATA) && !w_empty;
    assign w_push    = w_rx_valid && (!w_full || w_pop);
    assign w_ovf_set = w_rx_valid && w_full && !w_pop;
    assign w_ovf_clr = w_wr && (w_reg == KBD_REG_STATUS) && bus.cpu_data_in[1];

    // FIFO storage; no reset needed, contents are qualified by count_q
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_rx_byte;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= w_ovf_set | (ovf_q & ~w_ovf_clr);
        end
    end

`ifdef KEYBOARD_ERROR_COUNT_EN
    logic [7:0] errcnt_q;

    // Saturating error counter; an increment overrides a same-cycle clear
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            errcnt_q <= 8'd0;
        end else if (w_rx_err) begin
            errcnt_q <= sat_inc8(errcnt_q);
        end else if (w_wr && (w_reg == KBD_REG_ERRCNT)) begin
            errcnt_q <= 8'd0;
        end
    end

    assign w_errcnt = errcnt_q;
`else
    assign w_errcnt = 8'd0;
`endif

    // Read mux for the register selected this cycle
    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            KBD_REG_STATUS: begin
                w_rdata[0]    = !w_empty;
                w_rdata[1]    = ovf_q;
                w_rdata[15:8] = 8'(count_q);
            end
            KBD_REG_DATA: begin
                if (!w_empty) begin
                    w_rdata[7:0] = mem_q[rd_ptr_q];
                    w_rdata[8]   = 1'b1;
                end
            end
            KBD_REG_ERRCNT: w_rdata[7:0] = w_errcnt;
            default:        w_rdata = 32'd0;
        endcase
    end

    // One-cycle read latency: register the selected word
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_out_q <= 32'd0;
        end else begin
            data_out_q <= w_rdata;
        end
    end

    assign bus.cpu_data_out = data_out_q;

    // Address/data bits outside the decoded fields are intentionally ignored
    assign w_unused = ^{bus.cpu_addr_in[31:4], bus.cpu_addr_in[1:0],
                        bus.cpu_data_in[31:2], bus.cpu_data_in[0], w_rx_err};

endmodule : keyboard_controller
`default_nettype wire

// File: tb/tb_keyboard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keyboard_controller
//  Purpose  : Self-checking bench for keyboard_controller: register-map
//             vector table plus directed PS/2 frame sequences (parity error,
//             timeout, overflow, push/pop collision, reset and glitches).
//  Revision : 1.0  initial release
// ============================================================================
module tb_keyboard_controller;

    localparam int H       = 20;    // PS/2 half bit period in clk cycles
    localparam int TIMEOUT = 200;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    logic rst_in;
    logic ps2_clk;
    logic ps2_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd;
    logic t5_seen;

    keyboard_if bus ();

    keyboard_controller #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .ps2_clk_in  (ps2_clk),
        .ps2_data_in (ps2_data),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.cpu_addr_in         = addr;
        bus.cpu_data_in         = data;
        bus.cpu_write_enable_in = 4'b0010;
        @(negedge clk);
        bus.cpu_write_enable_in = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val);
        @(negedge clk);
        bus.cpu_addr_in         = addr;
        bus.cpu_write_enable_in = 4'b0000;
        @(negedge clk);
        val = bus.cpu_data_out;
    endtask

    task automatic rd_check(input string nm, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(addr, v);
        check(nm, v, exp);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Start, 8 data bits LSB first, odd parity (optionally corrupted), stop
    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0101, "t1_status"};
        vt[1]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h0000_011C, "t1_data"};
        vt[2]  = '{1'b0, 32'hABCD_0007, 32'h0, 32'h0000_011C, "t1_data_alias_reread"};
        vt[3]  = '{1'b0, 32'h0000_000C, 32'h0, 32'h0000_0000, "t1_reg3"};
        vt[4]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0, "t1_wr_reg3"};
        vt[5]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0101, "t1_status_after_reg3_wr"};
        vt[6]  = '{1'b1, 32'h0000_0004, 32'h0, 32'h0, "t1_pop"};
        vt[7]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, "t1_status_empty"};
        vt[8]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h0000_0000, "t1_data_empty"};
        vt[9]  = '{1'b1, 32'h0000_0004, 32'h0, 32'h0, "t1_pop_empty"};
        vt[10] = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, "t1_status_pop_empty"};

        bus.cpu_addr_in         = 32'h0;
        bus.cpu_data_in         = 32'h0;
        bus.cpu_write_enable_in = 4'h0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        t5_seen  = 1'b0;
        rst_in   = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_data_out", bus.cpu_data_out, 32'h0);
        rst_in = 1'b0;
        rd_check("reset_status", 32'h0, 32'h0);
        rd_check("reset_data",   32'h4, 32'h0);

        // Test 1: valid 0x1C frame, then register-map vector table
        send_frame(8'h1C, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].wdata);
            else          rd_check(vt[i].name, vt[i].addr, vt[i].exp);
        end

        // Test 2: parity error drops the frame
        send_frame(8'h1C, 1'b1);
        rd_check("t2_status", 32'h0, 32'h0);
`ifdef KEYBOARD_ERROR_COUNT_EN
        rd_check("t2_errcnt", 32'h8, 32'h1);
        bus_write(32'h8, 32'h0);
        rd_check("t2_errcnt_cleared", 32'h8, 32'h0);
`else
        rd_check("t2_errcnt", 32'h8, 32'h0);
`endif

        // Test 3: partial frame abandoned by timeout, then valid 0x5A
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 50) @(negedge clk);
        send_frame(8'h5A, 1'b0);
        rd_check("t3_status", 32'h0, 32'h0000_0101);
        rd_check("t3_data",   32'h4, 32'h0000_015A);
        bus_write(32'h4, 32'h0);

        // Test 4: overflow on the 17th frame, ordered drain, sticky flag
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b0);
        rd_check("t4_status_full_ovf", 32'h0, 32'h0000_1003);
        for (int i = 0; i < DEPTH; i++) begin
            rd_check($sformatf("t4_drain_%0d", i), 32'h4, 32'h100 | 32'(i));
            bus_write(32'h4, 32'h0);
        end
        rd_check("t4_status_empty_ovf", 32'h0, 32'h0000_0002);
        bus_write(32'h4, 32'h0);
        rd_check("t4_status_after_extra_pop", 32'h0, 32'h0000_0002);
        bus_write(32'h0, 32'h0000_0002);
        rd_check("t4_status_ovf_cleared", 32'h0, 32'h0);

        // Test 5: pop coincides with a push while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 1'b0);
        rd_check("t5_status_full", 32'h0, 32'h0000_1001);
        fork
            send_frame(8'h30, 1'b0);
            begin
                for (int k = 0; k < 2000 && !t5_seen; k++) begin
                    @(negedge clk);
                    if (dut.w_rx_valid) t5_seen = 1'b1;
                end
                if (t5_seen) begin
                    bus.cpu_addr_in         = 32'h4;
                    bus.cpu_write_enable_in = 4'b0001;
                    @(negedge clk);
                    bus.cpu_write_enable_in = 4'b0000;
                end
            end
        join
        check("t5_strobe_seen", {31'b0, t5_seen}, 32'h1);
        rd_check("t5_status_after_collision", 32'h0, 32'h0000_1001);
        for (int i = 1; i < DEPTH; i++) begin
            rd_check($sformatf("t5_drain_%0d", i), 32'h4, 32'h100 | (32'h20 + 32'(i)));
            bus_write(32'h4, 32'h0);
        end
        rd_check("t5_tail_new_byte", 32'h4, 32'h0000_0130);
        bus_write(32'h4, 32'h0);
        rd_check("t5_status_drained", 32'h0, 32'h0);

        // Test 6: reset during bit 4, then glitches, then valid 0x76
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H / 2) @(negedge clk);
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_in   = 1'b0;
        repeat (3 * H) @(negedge clk);
        rd_check("t6_status_after_reset", 32'h0, 32'h0);
        rd_check("t6_errcnt_after_reset", 32'h8, 32'h0);
        ps2_data = 1'b0;
        for (int g = 0; g < 6; g++) begin
            ps2_clk = 1'b0;
            @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        send_frame(8'h76, 1'b0);
        rd_check("t6_status", 32'h0, 32'h0000_0101);
        rd_check("t6_data",   32'h4, 32'h0000_0176);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_keyboard_controller
`default_nettype wire
